ppfifo_stream_reader: RTL and testbench
=======================================

Name: ppfifo_stream_reader

Overview:
- Downstream consumer of the ping-pong FIFO read side in the DMA writer path; replaces the discard-only data sink.
- Claims each ready read buffer, pops its words, and presents them on a valid/ready stream with a last flag on each buffer's final word.
- Uses a 2-entry skid buffer to hide the FIFO's registered read latency and sustain 1 word/cycle under backpressure.

Parameters:
- DATA_WIDTH, 32, stream and FIFO data width.
- SIZE_WIDTH, 24, width of the FIFO read count and internal word counters.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- i_enable  in  1  permit claiming new buffers
- i_rd_rdy  in  1  FIFO read buffer available
- o_rd_act  out  1  read buffer claimed
- i_rd_size  in  SIZE_WIDTH  words in the claimed buffer
- o_rd_stb  out  1  pop one word
- i_rd_data  in  DATA_WIDTH  FIFO read data; valid in the cycle after o_rd_stb
- o_axis_valid  out  1  stream word valid
- i_axis_ready  in  1  sink accepts word
- o_axis_data  out  DATA_WIDTH  stream word
- o_axis_last  out  1  final word of current buffer
- o_busy  out  1  buffer currently claimed
- o_buffer_done  out  1  one-cycle pulse when a buffer is released

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. All outputs are 0, the skid buffer is empty, counters are 0, and the state is IDLE.
- A reset asserted mid-buffer abandons the buffer immediately, and o_rd_act drops on the next edge.
- State machine: IDLE -> ACTIVE -> RELEASE -> IDLE.
- IDLE:
  - If i_enable & i_rd_rdy & !o_rd_act: latch i_rd_size into size_r, clear issued/popped counters, set o_rd_act and o_busy, go to ACTIVE.
- ACTIVE:
  - o_rd_stb = (issued < size_r) & (occ + inflight - pop) < 2, where:
    - occ = skid entries (0..2);
    - inflight = o_rd_stb registered from the previous cycle;
    - pop = o_axis_valid & i_axis_ready.
  - o_rd_stb is combinational from registered state and i_axis_ready.
  - Each strobe increments issued.
  - The cycle after a strobe, i_rd_data is written into the skid buffer, tagged last when the word index equals size_r-1.
  - o_axis_valid = occ != 0. o_axis_data and o_axis_last come from the skid head.
  - A pop increments popped. Push and pop may occur in the same cycle; occ then stays unchanged.
  - When popped reaches size_r (including the size_r=0 case), go to RELEASE.
- RELEASE:
  - o_rd_act drops, o_busy drops, o_buffer_done pulses for one cycle, go to IDLE.
  - IDLE's !o_rd_act term guarantees at least one cycle gap before the next claim.
- Latency:
  - i_rd_rdy seen in cycle N -> o_rd_act=1 in N+1 -> first o_rd_stb in N+1 -> data in N+2 -> o_axis_valid=1 in N+3.
- Throughput: 1 word/cycle while i_axis_ready is held high.
- Backpressure:
  - With i_axis_ready low, at most 2 words are outstanding (skid + in flight); no data is lost or duplicated.
  - o_axis_valid/data/last are held stable until accepted.
- Zero-size buffer: claim, issue no strobes, emit no stream beat, RELEASE. o_buffer_done still pulses.
- i_enable dropped mid-buffer: the current buffer completes normally; no new claim is made.
- Counter widths: SIZE_WIDTH. size_r = 2^SIZE_WIDTH-1 is legal; no wrap occurs within a buffer.

Optional Feature:
- Macro: PPFIFO_STREAM_READER_STATS_EN.
- When defined, adds ports:
  - o_word_count  out  32: total stream beats accepted since reset; wraps modulo 2^32.
  - o_stall_count  out  32: cycles with o_axis_valid & !i_axis_ready; saturates at 0xFFFFFFFF.
  - Both are 0 at reset.
- When undefined: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package/defines holds:
  - state encodings (IDLE=0, ACTIVE=1, RELEASE=2);
  - SKID_DEPTH=2;
  - stats counter width 32.
- One natural sub-module, stream_skid_buffer:
  - a 2-entry FIFO of {last, data};
  - ports push/pop/occ, with valid/ready on the output side.

Test Plan:
- Single buffer of size 4, data 0xA0..0xA3, ready held high -> 4 consecutive beats from N+3; last only on 0xA3; o_buffer_done pulses once; o_rd_act high exactly for the claim period.
- Size 8, ready toggling 1,0,0,1,... -> exactly 8 beats in order 0..7 with no duplicates; data stable while stalled; o_rd_stb never leaves more than 2 outstanding.
- Size 0 buffer -> no beat, o_rd_stb never asserts, o_buffer_done pulses, returns to IDLE.
- Two back-to-back ready buffers of size 3 and 5 -> 8 beats with last on the 3rd and 8th; at least a one-cycle o_rd_act low gap between the buffers.
- rst pulsed after 2 of 6 beats -> outputs 0 next cycle, o_rd_act=0; after reset a fresh buffer streams correctly.
- With PPFIFO_STREAM_READER_STATS_EN defined: 10 beats with 4 stall cycles -> o_word_count=10, o_stall_count=4.

Source files
------------

// File: rtl/ppfifo_stream_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ppfifo_stream_reader_pkg
// Description : Shared definitions for the ping-pong FIFO stream reader:
//               FSM state encoding, skid buffer depth and the width of
//               the optional statistics counters.
// Revision    : 1.0 - initial release
// ============================================================================
package ppfifo_stream_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  localparam int SKID_DEPTH  = 2;
  localparam int STATS_WIDTH = 32;

endpackage
`default_nettype wire

// File: rtl/ppfifo_stream_reader_skid.sv
`default_nettype none
// ============================================================================
// Module      : stream_skid_buffer
// Description : Two-entry FIFO of {last, data} that absorbs the FIFO's
//               registered read latency and presents a valid/ready stream.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               push_i          - write push_data_i/push_last_i this cycle
//               valid_o/ready_i - output handshake (valid = not empty)
//               data_o, last_o  - head entry
//               occ_o           - number of stored entries (0..2)
// Revision    : 1.0 - initial release
// ============================================================================
module stream_skid_buffer
  import ppfifo_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  push_last_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  last_o,
  output logic [1:0]            occ_o
);

  logic [DATA_WIDTH:0] mem_q [SKID_DEPTH];
  logic                wr_ptr_q;
  logic                rd_ptr_q;
  logic [1:0]          occ_q;
  logic                w_pop;

  assign valid_o = (occ_q != 2'd0);
  assign w_pop   = valid_o & ready_i;
  assign data_o  = mem_q[rd_ptr_q][DATA_WIDTH-1:0];
  assign last_o  = mem_q[rd_ptr_q][DATA_WIDTH];
  assign occ_o   = occ_q;

  // The reader never pushes into a full buffer, so push is not gated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SKID_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= {push_last_i, push_data_i};
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (w_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push_i, w_pop})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/ppfifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : ppfifo_stream_reader
// Description : Claims ready ping-pong FIFO read buffers, pops their words
//               and presents them as a valid/ready stream with a last flag
//               on each buffer's final word.
// Ports       : i_enable              - permit claiming new buffers
//               i_rd_rdy/o_rd_act     - buffer available / buffer claimed
//               i_rd_size             - word count of the claimed buffer
//               o_rd_stb/i_rd_data    - pop strobe / data one cycle later
//               o_axis_*/i_axis_ready - output stream
//               o_busy, o_buffer_done - claim status / release pulse
// Options     : PPFIFO_STREAM_READER_STATS_EN adds o_word_count (accepted
//               beats, wrapping) and o_stall_count (valid & !ready cycles,
//               saturating).
// Revision    : 1.0 - initial release
// ============================================================================
module ppfifo_stream_reader
  import ppfifo_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SIZE_WIDTH = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_enable,
  input  logic                   i_rd_rdy,
  output logic                   o_rd_act,
  input  logic [SIZE_WIDTH-1:0]  i_rd_size,
  output logic                   o_rd_stb,
  input  logic [DATA_WIDTH-1:0]  i_rd_data,
  output logic                   o_axis_valid,
  input  logic                   i_axis_ready,
  output logic [DATA_WIDTH-1:0]  o_axis_data,
  output logic                   o_axis_last,
  output logic                   o_busy,
  output logic                   o_buffer_done
`ifdef PPFIFO_STREAM_READER_STATS_EN
  ,
  output logic [STATS_WIDTH-1:0] o_word_count,
  output logic [STATS_WIDTH-1:0] o_stall_count
`endif
);

  state_e                state_q, state_d;
  logic [SIZE_WIDTH-1:0] size_q, size_d;
  logic [SIZE_WIDTH-1:0] issued_q, issued_d;
  logic [SIZE_WIDTH-1:0] popped_q, popped_d;
  logic                  inflight_q;

  logic                  w_pop;
  logic [1:0]            w_occ;
  logic [2:0]            w_outstanding;
  logic                  w_push_last;

  assign w_pop = o_axis_valid & i_axis_ready;

  // The word arriving now was strobed last cycle, so issued_q already counts
  // it: it is the final word exactly when issued_q has reached size_q.
  assign w_push_last = (issued_q == size_q);

  stream_skid_buffer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .push_i      (inflight_q),
    .push_data_i (i_rd_data),
    .push_last_i (w_push_last),
    .valid_o     (o_axis_valid),
    .ready_i     (i_axis_ready),
    .data_o      (o_axis_data),
    .last_o      (o_axis_last),
    .occ_o       (w_occ)
  );

  // Skid slots that stay committed after this cycle's pop; a new strobe is
  // allowed only while one slot remains free for its data.
  assign w_outstanding = {1'b0, w_occ} + {2'b00, inflight_q} - {2'b00, w_pop};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      size_q     <= '0;
      issued_q   <= '0;
      popped_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      size_q     <= size_d;
      issued_q   <= issued_d;
      popped_q   <= popped_d;
      inflight_q <= o_rd_stb;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    size_d   = size_q;
    issued_d = issued_q;
    popped_d = popped_q;
    case (state_q)
      ST_IDLE: begin
        if (i_enable && i_rd_rdy && !o_rd_act) begin
          state_d  = ST_ACTIVE;
          size_d   = i_rd_size;
          issued_d = '0;
          popped_d = '0;
        end
      end
      ST_ACTIVE: begin
        if (o_rd_stb) begin
          issued_d = issued_q + 1'b1;
        end
        if (w_pop) begin
          popped_d = popped_q + 1'b1;
        end
        // Leave right after the final acceptance; a zero-size buffer
        // leaves on its first active cycle.
        if (popped_d == size_q) begin
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    o_rd_act      = (state_q == ST_ACTIVE);
    o_busy        = (state_q == ST_ACTIVE);
    o_buffer_done = (state_q == ST_RELEASE);
    o_rd_stb      = (state_q == ST_ACTIVE) && (issued_q < size_q) &&
                    (w_outstanding < 3'(SKID_DEPTH));
  end

`ifdef PPFIFO_STREAM_READER_STATS_EN
  logic [STATS_WIDTH-1:0] word_count_q;
  logic [STATS_WIDTH-1:0] stall_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      word_count_q  <= '0;
      stall_count_q <= '0;
    end else begin
      if (w_pop) begin
        word_count_q <= word_count_q + 1'b1;
      end
      if (o_axis_valid && !i_axis_ready && (stall_count_q != '1)) begin
        stall_count_q <= stall_count_q + 1'b1;
      end
    end
  end

  assign o_word_count  = word_count_q;
  assign o_stall_count = stall_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ppfifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_ppfifo_stream_reader
// Description : Self-checking bench for ppfifo_stream_reader. A queue-based
//               model of the FIFO read side supplies buffers and data; the
//               expected stream is the concatenation of all buffer words
//               with last on each buffer's final word.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ppfifo_stream_reader;

  localparam int DW = 32;
  localparam int SW = 24;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_enable = 1'b1;
  logic          i_rd_rdy = 1'b0;
  logic          o_rd_act;
  logic [SW-1:0] i_rd_size = '0;
  logic          o_rd_stb;
  logic [DW-1:0] i_rd_data = '0;
  logic          o_axis_valid;
  logic          i_axis_ready = 1'b1;
  logic [DW-1:0] o_axis_data;
  logic          o_axis_last;
  logic          o_busy;
  logic          o_buffer_done;
`ifdef PPFIFO_STREAM_READER_STATS_EN
  logic [31:0]   o_word_count;
  logic [31:0]   o_stall_count;
`endif

  always #5 clk = ~clk;

  ppfifo_stream_reader #(.DATA_WIDTH(DW), .SIZE_WIDTH(SW)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_enable      (i_enable),
    .i_rd_rdy      (i_rd_rdy),
    .o_rd_act      (o_rd_act),
    .i_rd_size     (i_rd_size),
    .o_rd_stb      (o_rd_stb),
    .i_rd_data     (i_rd_data),
    .o_axis_valid  (o_axis_valid),
    .i_axis_ready  (i_axis_ready),
    .o_axis_data   (o_axis_data),
    .o_axis_last   (o_axis_last),
    .o_busy        (o_busy),
    .o_buffer_done (o_buffer_done)
`ifdef PPFIFO_STREAM_READER_STATS_EN
    ,
    .o_word_count  (o_word_count),
    .o_stall_count (o_stall_count)
`endif
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Model state
  int            pend_sizes[$];
  logic [DW-1:0] pend_words[$];
  logic [DW-1:0] cur_words[$];
  logic [DW:0]   exp_q[$];
  logic [DW:0]   beats[$];
  int            beat_cyc[$];

  // Observations
  int   claims, claim_cyc, rdy_cyc, act_cycles, done_count, done_cyc;
  int   stb_total, acc_total, stab_err, outst_err, overread, gap, stall_seen;
  logic act_prev, stall_prev;
  logic [DW:0] prev_beat;
  int   ready_mode, rp;
  logic [DW+5:0] s_outs;

  task automatic clear_obs();
    claims = 0; claim_cyc = -1; rdy_cyc = -1; act_cycles = 0;
    done_count = 0; done_cyc = -1; stb_total = 0; acc_total = 0;
    stab_err = 0; outst_err = 0; overread = 0; gap = 0; stall_seen = 0;
    beats.delete(); beat_cyc.delete(); exp_q.delete();
  endtask

  task automatic enqueue(input int sz, input logic [DW-1:0] base, input bit rnd);
    logic [DW-1:0] w;
    for (int i = 0; i < sz; i++) begin
      w = rnd ? DW'($urandom) : base + DW'(i);
      pend_words.push_back(w);
      exp_q.push_back({(i == sz - 1), w});
    end
    pend_sizes.push_back(sz);
  endtask

  // One clock cycle: observe at the falling edge, drive after the rising edge.
  task automatic tick();
    bit stb_now;
    int sz;
    @(negedge clk);
    cyc++;
    stb_now = o_rd_stb;
    s_outs  = {o_rd_act, o_rd_stb, o_axis_valid, o_axis_last, o_busy,
               o_buffer_done, o_axis_data};
    if (i_rd_rdy && rdy_cyc < 0) rdy_cyc = cyc;
    if (o_rd_act && !act_prev) begin
      claims++;
      if (claims == 1) claim_cyc = cyc;
      sz = pend_sizes.pop_front();
      for (int i = 0; i < sz; i++) cur_words.push_back(pend_words.pop_front());
    end
    if (claims == 1 && !o_rd_act) gap++;
    if (o_rd_act) act_cycles++;
    if (o_rd_stb) stb_total++;
    if (stall_prev && !(o_axis_valid && {o_axis_last, o_axis_data} == prev_beat))
      stab_err++;
    stall_prev = o_axis_valid && !i_axis_ready;
    if (stall_prev) stall_seen++;
    prev_beat = {o_axis_last, o_axis_data};
    if (o_axis_valid && i_axis_ready) begin
      beats.push_back({o_axis_last, o_axis_data});
      beat_cyc.push_back(cyc);
      acc_total++;
    end
    if (stb_total - acc_total > 2) outst_err++;
    if (o_buffer_done) begin done_count++; done_cyc = cyc; end
    act_prev = o_rd_act;
    @(posedge clk);
    #1;
    if (stb_now) begin
      if (cur_words.size() != 0) i_rd_data = cur_words.pop_front();
      else begin overread++; i_rd_data = DW'($urandom); end
    end else begin
      i_rd_data = DW'($urandom);
    end
    i_rd_rdy  = (pend_sizes.size() != 0);
    i_rd_size = i_rd_rdy ? SW'(pend_sizes[0]) : SW'($urandom);
    case (ready_mode)
      0:       i_axis_ready = 1'b1;
      1:       begin i_axis_ready = (rp % 3 == 0); rp++; end
      default: i_axis_ready = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  task automatic wait_done(input int target, input int budget, output bit ok);
    int n = 0;
    while (done_count < target && n < budget) begin tick(); n++; end
    ok = (done_count >= target);
  endtask

  task automatic test_reset();
    rst = 1'b1; ready_mode = 0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    n_vec++;
    if (s_outs !== '0) begin
      n_err++; $display("FAIL reset_outputs: got %h, expected 0", s_outs);
    end
`ifdef PPFIFO_STREAM_READER_STATS_EN
    n_vec++;
    if (o_word_count !== 32'd0 || o_stall_count !== 32'd0) begin
      n_err++; $display("FAIL reset_stats: got %0d/%0d, expected 0/0", o_word_count, o_stall_count);
    end
`endif
    act_prev = 1'b0; stall_prev = 1'b0;
  endtask

  task automatic test_single();
    bit ok;
    clear_obs(); ready_mode = 0;
    enqueue(4, 32'hA0, 1'b0);
    wait_done(1, 60, ok);
    repeat (3) tick();
    n_vec++; if (!ok) begin n_err++; $display("FAIL single_timeout: done %0d, expected 1", done_count); end
    n_vec++; if (claim_cyc !== rdy_cyc + 1) begin n_err++; $display("FAIL single_claim_lat: act at %0d, expected %0d", claim_cyc, rdy_cyc + 1); end
    n_vec++; if (beats.size() !== 4) begin n_err++; $display("FAIL single_count: got %0d beats, expected 4", beats.size()); end
    for (int i = 0; i < beats.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (beats[i] !== exp_q[i]) begin n_err++; $display("FAIL single_beat%0d: got %h, expected %h", i, beats[i], exp_q[i]); end
    end
    if (beat_cyc.size() == 4) begin
      n_vec++; if (beat_cyc[0] !== claim_cyc + 2) begin n_err++; $display("FAIL single_first_lat: beat at %0d, expected %0d", beat_cyc[0], claim_cyc + 2); end
      n_vec++; if (beat_cyc[3] !== beat_cyc[0] + 3) begin n_err++; $display("FAIL single_throughput: last beat at %0d, expected %0d", beat_cyc[3], beat_cyc[0] + 3); end
      n_vec++; if (done_cyc !== beat_cyc[3] + 1) begin n_err++; $display("FAIL single_done_cyc: done at %0d, expected %0d", done_cyc, beat_cyc[3] + 1); end
    end
    n_vec++; if (done_count !== 1) begin n_err++; $display("FAIL single_done_count: got %0d, expected 1", done_count); end
    n_vec++; if (act_cycles !== 6) begin n_err++; $display("FAIL single_act_cycles: got %0d, expected 6", act_cycles); end
    n_vec++; if (stb_total !== 4) begin n_err++; $display("FAIL single_strobes: got %0d, expected 4", stb_total); end
  endtask

  task automatic test_backpressure();
    bit ok;
    clear_obs(); ready_mode = 1; rp = 0;
    enqueue(8, 32'h0, 1'b0);
    wait_done(1, 150, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL bp_timeout: done %0d, expected 1", done_count); end
    n_vec++; if (beats.size() !== 8) begin n_err++; $display("FAIL bp_count: got %0d beats, expected 8", beats.size()); end
    for (int i = 0; i < beats.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (beats[i] !== exp_q[i]) begin n_err++; $display("FAIL bp_beat%0d: got %h, expected %h", i, beats[i], exp_q[i]); end
    end
    n_vec++; if (stab_err !== 0) begin n_err++; $display("FAIL bp_stable: %0d unstable stalls, expected 0", stab_err); end
    n_vec++; if (outst_err !== 0 || overread !== 0) begin n_err++; $display("FAIL bp_outstanding: %0d/%0d violations, expected 0/0", outst_err, overread); end
  endtask

  task automatic test_zero();
    bit ok;
    clear_obs(); ready_mode = 0;
    enqueue(0, 32'h0, 1'b0);
    wait_done(1, 30, ok);
    repeat (3) tick();
    n_vec++; if (!ok || done_count !== 1) begin n_err++; $display("FAIL zero_done: got %0d, expected 1", done_count); end
    n_vec++; if (beats.size() !== 0 || stb_total !== 0) begin n_err++; $display("FAIL zero_activity: %0d beats %0d strobes, expected 0/0", beats.size(), stb_total); end
    n_vec++; if (act_cycles !== 1 || s_outs[DW+5] !== 1'b0) begin n_err++; $display("FAIL zero_act: %0d cycles, now %b, expected 1/0", act_cycles, s_outs[DW+5]); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_obs(); ready_mode = 0;
    enqueue(3, 32'h300, 1'b0);
    enqueue(5, 32'h500, 1'b0);
    wait_done(2, 80, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL b2b_timeout: done %0d, expected 2", done_count); end
    n_vec++; if (beats.size() !== 8) begin n_err++; $display("FAIL b2b_count: got %0d beats, expected 8", beats.size()); end
    for (int i = 0; i < beats.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (beats[i] !== exp_q[i]) begin n_err++; $display("FAIL b2b_beat%0d: got %h, expected %h", i, beats[i], exp_q[i]); end
    end
    n_vec++; if (claims !== 2 || gap < 1) begin n_err++; $display("FAIL b2b_gap: claims %0d gap %0d, expected 2 and >=1", claims, gap); end
  endtask

  task automatic test_enable_drop();
    bit ok;
    int n = 0;
    clear_obs(); ready_mode = 2;
    enqueue(5, 32'h0, 1'b1);
    enqueue(2, 32'h0, 1'b1);
    while (claims == 0 && n < 20) begin tick(); n++; end
    i_enable = 1'b0;
    wait_done(1, 100, ok);
    repeat (10) tick();
    n_vec++; if (!ok || claims !== 1 || beats.size() !== 5) begin n_err++; $display("FAIL en_hold: claims %0d beats %0d, expected 1/5", claims, beats.size()); end
    i_enable = 1'b1;
    wait_done(2, 100, ok);
    n_vec++; if (beats.size() !== 7) begin n_err++; $display("FAIL en_count: got %0d beats, expected 7", beats.size()); end
    for (int i = 0; i < beats.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (beats[i] !== exp_q[i]) begin n_err++; $display("FAIL en_beat%0d: got %h, expected %h", i, beats[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n = 0;
    clear_obs(); ready_mode = 0;
    enqueue(6, 32'h600, 1'b0);
    while (beats.size() < 2 && n < 30) begin tick(); n++; end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    n_vec++;
    if (s_outs !== '0) begin n_err++; $display("FAIL rstmid_outputs: got %h, expected 0", s_outs); end
    pend_sizes.delete(); pend_words.delete(); cur_words.delete();
    clear_obs(); act_prev = 1'b0; stall_prev = 1'b0;
    enqueue(5, 32'h0, 1'b1);
    wait_done(1, 60, ok);
    n_vec++; if (!ok || beats.size() !== 5) begin n_err++; $display("FAIL rstmid_count: got %0d beats, expected 5", beats.size()); end
    for (int i = 0; i < beats.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (beats[i] !== exp_q[i]) begin n_err++; $display("FAIL rstmid_beat%0d: got %h, expected %h", i, beats[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    bit ok;
    clear_obs(); ready_mode = 2;
    for (int b = 0; b < 4; b++) enqueue($urandom_range(0, 12), 32'h0, 1'b1);
    wait_done(4, 500, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL rnd_timeout: done %0d, expected 4", done_count); end
    n_vec++; if (beats.size() !== exp_q.size()) begin n_err++; $display("FAIL rnd_count: got %0d beats, expected %0d", beats.size(), exp_q.size()); end
    for (int i = 0; i < beats.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (beats[i] !== exp_q[i]) begin n_err++; $display("FAIL rnd_beat%0d: got %h, expected %h", i, beats[i], exp_q[i]); end
    end
    n_vec++; if (stab_err !== 0 || outst_err !== 0 || overread !== 0) begin n_err++; $display("FAIL rnd_protocol: stab %0d outst %0d over %0d, expected 0", stab_err, outst_err, overread); end
  endtask

`ifdef PPFIFO_STREAM_READER_STATS_EN
  task automatic test_stats();
    bit ok;
    test_reset();
    clear_obs(); ready_mode = 1; rp = 0;
    enqueue(10, 32'h0, 1'b1);
    wait_done(1, 200, ok);
    n_vec++; if (o_word_count !== 32'd10) begin n_err++; $display("FAIL stats_words: got %0d, expected 10", o_word_count); end
    n_vec++; if (o_stall_count !== 32'(stall_seen)) begin n_err++; $display("FAIL stats_stalls: got %0d, expected %0d", o_stall_count, stall_seen); end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    act_prev = 1'b0; stall_prev = 1'b0; prev_beat = '0; rp = 0;
    clear_obs();
    test_reset();
    test_single();
    test_backpressure();
    test_zero();
    test_back_to_back();
    test_enable_drop();
    test_reset_mid();
    test_random();
`ifdef PPFIFO_STREAM_READER_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
